// File: rtl/noise_frame_scheduler.sv
// noise_frame_scheduler: gathers pixels into a block buffer, replays each block to the
// noise_estimation datapath as a gap-free burst and hands out the frame noise estimate.
module noise_frame_scheduler #(
    parameter int DATA_WIDTH     = 8,
    parameter int TOTAL_SAMPLES  = 8,
    parameter int GAP_CYCLES     = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             cfg_blocks_per_frame,
    input  logic                    frame_start,
    input  logic [DATA_WIDTH-1:0]   s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic                    ne_start_of_frame,
    output logic [DATA_WIDTH-1:0]   ne_data,
    output logic                    ne_start_data,
    output logic [31:0]             ne_blocks_per_frame,
    input  logic [2*DATA_WIDTH-1:0] ne_estimated_noise,
    input  logic                    ne_estimated_noise_ready,
    output logic [2*DATA_WIDTH-1:0] noise_out,
    output logic                    noise_valid,
    input  logic                    noise_ack,
    output logic                    busy,
    output logic                    frame_error
);
    localparam int AW = $clog2(TOTAL_SAMPLES);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(TOTAL_SAMPLES - 1);
    localparam logic [PW-1:0] FULL_CNT = PW'(TOTAL_SAMPLES);
    localparam logic [31:0]   GAP_LAST = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : '0;
    localparam logic [31:0]   TMO_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        IDLE, ARM, FILL, BURST, GAP, WAIT_RES, HOLD
    } state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         fill_cnt, rd_ptr;
    logic [31:0]           blk_cnt, gap_cnt, tmo_cnt;
    logic [DATA_WIDTH-1:0] blk_buf [TOTAL_SAMPLES];
    logic                  accept, fill_done, burst_last, frame_last;
    logic                  latch_cfg, capture, err_d;

    assign s_ready           = (state_q == FILL) && (fill_cnt < FULL_CNT);
    assign ne_start_of_frame = (state_q == ARM);
    assign noise_valid       = (state_q == HOLD);
    assign busy              = (state_q != IDLE);
    assign accept            = s_valid && s_ready;
    assign fill_done         = accept && (fill_cnt == LAST_IDX);
    assign burst_last        = (rd_ptr == LAST_IDX);
    assign frame_last        = ((blk_cnt + 32'd1) == ne_blocks_per_frame);

    always_comb begin
        state_d   = state_q;
        latch_cfg = 1'b0;
        capture   = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    if (cfg_blocks_per_frame == '0) begin
                        err_d = 1'b1;
                    end else begin
                        latch_cfg = 1'b1;
                        state_d   = ARM;
                    end
                end
            end
            ARM:  state_d = FILL;
            FILL: if (fill_done) state_d = BURST;
            BURST: begin
                if (burst_last) begin
                    if (frame_last)           state_d = WAIT_RES;
                    else if (GAP_CYCLES == 0) state_d = FILL;
                    else                      state_d = GAP;
                end
            end
            GAP: if (gap_cnt == GAP_LAST) state_d = FILL;
            WAIT_RES: begin
                if (ne_estimated_noise_ready) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end else if (tmo_cnt == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            HOLD: begin
                // an ack coinciding with frame_start re-arms without visiting IDLE
                if (noise_ack) begin
                    state_d = IDLE;
                    if (frame_start) begin
                        if (cfg_blocks_per_frame == '0) begin
                            err_d = 1'b1;
                        end else begin
                            latch_cfg = 1'b1;
                            state_d   = ARM;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (frame_start && (state_q != IDLE) && !((state_q == HOLD) && noise_ack))
            err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q             <= IDLE;
            fill_cnt            <= '0;
            rd_ptr              <= '0;
            blk_cnt             <= '0;
            gap_cnt             <= '0;
            tmo_cnt             <= '0;
            ne_data             <= '0;
            ne_start_data       <= 1'b0;
            ne_blocks_per_frame <= '0;
            noise_out           <= '0;
            frame_error         <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_error   <= err_d;
            ne_start_data <= 1'b0;
            ne_data       <= '0;
            if (latch_cfg) begin
                ne_blocks_per_frame <= cfg_blocks_per_frame;
                blk_cnt             <= '0;
                fill_cnt            <= '0;
            end
            // sample 0 is preloaded as the last pixel lands so the burst starts one cycle later
            if (fill_done) begin
                fill_cnt      <= '0;
                rd_ptr        <= '0;
                ne_data       <= blk_buf[0];
                ne_start_data <= 1'b1;
            end else if (accept) begin
                fill_cnt <= fill_cnt + PW'(1);
            end
            if (state_q == BURST) begin
                if (burst_last) begin
                    blk_cnt <= blk_cnt + 32'd1;
                    rd_ptr  <= '0;
                end else begin
                    rd_ptr  <= rd_ptr + PW'(1);
                    ne_data <= blk_buf[rd_ptr[AW-1:0] + AW'(1)];
                end
            end
            gap_cnt <= (state_q == GAP)      ? gap_cnt + 32'd1 : '0;
            tmo_cnt <= (state_q == WAIT_RES) ? tmo_cnt + 32'd1 : '0;
            if (capture) noise_out <= ne_estimated_noise;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) blk_buf[fill_cnt[AW-1:0]] <= s_data;
    end

endmodule

// File: tb/tb_noise_frame_scheduler.sv
// Bench for noise_frame_scheduler: timeline-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_noise_frame_scheduler;
    localparam int DW  = 8;
    localparam int TS  = 8;
    localparam int GAP = 1;
    localparam int TMO = 40;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   cfg_blocks_per_frame = '0;
    logic          frame_start = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          ne_start_of_frame;
    logic [DW-1:0] ne_data;
    logic          ne_start_data;
    logic [31:0]   ne_blocks_per_frame;
    logic [2*DW-1:0] ne_estimated_noise = '0;
    logic          ne_estimated_noise_ready = 1'b0;
    logic [2*DW-1:0] noise_out;
    logic          noise_valid;
    logic          noise_ack = 1'b0;
    logic          busy;
    logic          frame_error;

    noise_frame_scheduler #(
        .DATA_WIDTH(DW), .TOTAL_SAMPLES(TS), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_blocks_per_frame(cfg_blocks_per_frame), .frame_start(frame_start),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .ne_start_of_frame(ne_start_of_frame), .ne_data(ne_data),
        .ne_start_data(ne_start_data), .ne_blocks_per_frame(ne_blocks_per_frame),
        .ne_estimated_noise(ne_estimated_noise),
        .ne_estimated_noise_ready(ne_estimated_noise_ready),
        .noise_out(noise_out), .noise_valid(noise_valid), .noise_ack(noise_ack),
        .busy(busy), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expectations are timestamps of when each phase of the frame
    // must be visible, derived from the accepted-pixel stream.
    int            t = 0;
    bit            frame_on, fill_on;
    int            arm_at, fill_from, burst_at, wait_from, hold_from, err_at, blocks_done;
    logic [DW-1:0] q[$];
    logic [DW-1:0] bdata[TS];
    logic [31:0]   m_bpf;
    logic [2*DW-1:0] m_noise;
    bit            e_ready, in_burst, e_hold;

    task automatic model_reset();
        frame_on = 0; fill_on = 0; arm_at = -1; fill_from = -1; burst_at = -1;
        wait_from = -1; hold_from = -1; err_at = -1; blocks_done = 0;
        m_bpf = '0; m_noise = '0; q.delete();
    endtask

    task automatic model_start();
        frame_on = 1; arm_at = t + 1; fill_on = 1; fill_from = t + 2;
        m_bpf = cfg_blocks_per_frame; blocks_done = 0;
        wait_from = -1; hold_from = -1; q.delete();
    endtask

    always @(negedge clk) begin
        t++;
        if (rst) begin
            model_reset();
            chk("rst_busy", busy, 0);
            chk("rst_s_ready", s_ready, 0);
            chk("rst_sof", ne_start_of_frame, 0);
            chk("rst_start_data", ne_start_data, 0);
            chk("rst_ne_data", ne_data, 0);
            chk("rst_noise_valid", noise_valid, 0);
            chk("rst_frame_error", frame_error, 0);
        end else begin
            e_ready  = fill_on && (t >= fill_from);
            in_burst = (burst_at >= 0) && (t >= burst_at) && (t < burst_at + TS);
            e_hold   = (hold_from >= 0) && (t >= hold_from);
            chk("m_s_ready", s_ready, e_ready);
            chk("m_sof", ne_start_of_frame, t == arm_at);
            chk("m_start_data", ne_start_data, in_burst && (t == burst_at));
            if (in_burst) chk("m_ne_data", ne_data, bdata[t - burst_at]);
            chk("m_busy", busy, frame_on);
            chk("m_noise_valid", noise_valid, e_hold);
            chk("m_noise_out", noise_out, m_noise);
            chk("m_frame_error", frame_error, t == err_at);
            chk("m_bpf", ne_blocks_per_frame, m_bpf);

            if (frame_start && !frame_on) begin
                if (cfg_blocks_per_frame == 0) err_at = t + 1;
                else model_start();
            end else if (frame_start && !(e_hold && noise_ack)) begin
                err_at = t + 1;
            end
            if (e_ready && s_valid) begin
                q.push_back(s_data);
                if (q.size() == TS) begin
                    for (int i = 0; i < TS; i++) bdata[i] = q[i];
                    q.delete();
                    burst_at = t + 1;
                    fill_on = 0;
                    blocks_done++;
                    if (32'(blocks_done) == m_bpf) wait_from = t + 1 + TS;
                    else begin
                        fill_on = 1;
                        fill_from = t + 1 + TS + GAP;
                    end
                end
            end
            if ((wait_from >= 0) && (t >= wait_from)) begin
                if (ne_estimated_noise_ready) begin
                    m_noise = ne_estimated_noise;
                    hold_from = t + 1;
                    wait_from = -1;
                end else if (t == wait_from + TMO - 1) begin
                    err_at = t + 1;
                    frame_on = 0;
                    wait_from = -1;
                end
            end
            if (e_hold && noise_ack) begin
                hold_from = -1;
                frame_on = 0;
                if (frame_start) begin
                    if (cfg_blocks_per_frame == 0) err_at = t + 1;
                    else model_start();
                end
            end
        end
    end

    // Observation of the burst stream for the literal checks
    int            sof_cnt = 0;
    int            bleft = 0;
    bit            nv_seen = 0;
    logic [DW-1:0] seen[$];

    always @(negedge clk) begin
        if (rst) begin
            bleft = 0;
        end else begin
            if (ne_start_of_frame) sof_cnt++;
            if (noise_valid) nv_seen = 1;
            if (ne_start_data) bleft = TS;
            if (bleft > 0) begin
                seen.push_back(ne_data);
                bleft--;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] cfg);
        cfg_blocks_per_frame = cfg;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send_pixels(input int first, input int n, input bit toggle);
        int sent = 0;
        int budget = 0;
        bit ph = 1;
        bit acc;
        while (sent < n && budget < 500) begin
            s_valid = toggle ? ph : 1'b1;
            s_data  = DW'(first + sent);
            @(negedge clk);
            acc = s_valid && s_ready;
            tick();
            if (acc) sent++;
            ph = !ph;
            budget++;
        end
        s_valid = 1'b0;
        chk("pixels_accepted", sent, n);
    endtask

    task automatic finish_frame(input logic [2*DW-1:0] nval);
        ne_estimated_noise = nval;
        ne_estimated_noise_ready = 1'b1;
        tick();
        ne_estimated_noise_ready = 1'b0;
        noise_ack = 1'b1;
        tick();
        noise_ack = 1'b0;
    endtask

    initial begin
        bit got;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // 1: reset in the middle of a burst
        pulse_start(1);
        send_pixels(50, 8, 0);
        repeat (3) tick();
        chk("t1_mid_burst_data", ne_data, 53);
        rst = 1'b1;
        #1;
        chk("t1_rst_ne_data", ne_data, 0);
        chk("t1_rst_busy", busy, 0);
        chk("t1_rst_bpf", ne_blocks_per_frame, 0);
        tick();
        rst = 1'b0;
        tick();

        // 2 + 4: two blocks back to back, result returned then held until ack
        sof_cnt = 0;
        seen.delete();
        pulse_start(2);
        send_pixels(0, 16, 0);
        repeat (TS + 4) tick();
        ne_estimated_noise = 16'h1234;
        ne_estimated_noise_ready = 1'b1;
        tick();
        ne_estimated_noise_ready = 1'b0;
        ne_estimated_noise = '0;
        for (int i = 0; i < 20 && !noise_valid; i++) tick();
        for (int i = 0; i < 10; i++) begin
            chk("t4_hold_valid", noise_valid, 1);
            chk("t4_hold_value", noise_out, 16'h1234);
            tick();
        end
        noise_ack = 1'b1;
        tick();
        noise_ack = 1'b0;
        chk("t4_valid_dropped", noise_valid, 0);
        chk("t4_idle", busy, 0);
        chk("t2_sof_count", sof_cnt, 1);
        chk("t2_burst_len", seen.size(), 16);
        chk("t2_first_burst_head", seen[0], 0);
        chk("t2_second_burst_head", seen[8], 8);
        chk("t2_last_sample", seen[15], 15);

        // 3: gappy input, burst order must match input order
        seen.delete();
        pulse_start(1);
        send_pixels(100, 8, 1);
        repeat (TS + 2) tick();
        for (int i = 0; i < TS; i++) chk("t3_order", seen[i], 100 + i);
        finish_frame(16'h00ab);
        chk("t3_noise", noise_out, 16'h00ab);

        // 5: zero-block frame request, then frame_start during FILL
        cfg_blocks_per_frame = 0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("t5_zero_err", frame_error, 1);
        chk("t5_zero_busy", busy, 0);
        tick();
        chk("t5_err_single", frame_error, 0);
        seen.delete();
        pulse_start(1);
        send_pixels(200, 3, 0);
        cfg_blocks_per_frame = 5;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("t5_fill_err", frame_error, 1);
        chk("t5_cfg_kept", ne_blocks_per_frame, 1);
        send_pixels(203, 5, 0);
        repeat (TS + 1) tick();
        chk("t5_burst_intact", seen[3], 203);
        finish_frame(16'h0042);
        chk("t5_noise", noise_out, 16'h0042);

        // 6: result timeout, then ack coinciding with a new frame_start
        nv_seen = 0;
        pulse_start(1);
        send_pixels(10, 8, 0);
        got = 0;
        for (int i = 0; i < TMO + TS + 20 && !got; i++) begin
            tick();
            if (frame_error) got = 1;
        end
        chk("t6_timeout_err", got, 1);
        chk("t6_timeout_idle", busy, 0);
        chk("t6_never_valid", nv_seen, 0);
        pulse_start(1);
        send_pixels(20, 8, 0);
        repeat (TS) tick();
        ne_estimated_noise = 16'h0777;
        ne_estimated_noise_ready = 1'b1;
        tick();
        ne_estimated_noise_ready = 1'b0;
        chk("t6_hold", noise_valid, 1);
        noise_ack = 1'b1;
        frame_start = 1'b1;
        cfg_blocks_per_frame = 3;
        tick();
        noise_ack = 1'b0;
        frame_start = 1'b0;
        chk("t6_rearm_sof", ne_start_of_frame, 1);
        chk("t6_rearm_bpf", ne_blocks_per_frame, 3);
        chk("t6_rearm_valid", noise_valid, 0);
        chk("t6_rearm_no_err", frame_error, 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
